// File: rtl/localbus_arbiter.sv
// Two-master localbus arbiter: round-robin with bounded bus locking and
// one-cycle-latency read-data return routed back to the issuing master.
module localbus_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m1_req,
  input  logic            m0_lock,
  input  logic            m1_lock,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [2:0]      m0_we,
  input  logic [2:0]      m1_we,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_we,
  input  logic [XLEN-1:0] bus_rdata
);

  // state | meaning
  // IDLE  | no master was granted in the previous cycle
  // OWN0  | m0 was granted in the previous cycle
  // OWN1  | m1 was granted in the previous cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  state_t     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       lock_q, lock_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  logic own_is_m1;
  logic own_req;
  logic other_req;
  logic lock_act;

  always_comb begin
    own_is_m1 = (state_q == OWN1);
    own_req   = own_is_m1 ? m1_req : m0_req;
    other_req = own_is_m1 ? m0_req : m1_req;
    lock_act  = (state_q != IDLE) && lock_q && own_req && (lock_cnt_q < MAX_CNT);

    // Grants are forced low while reset is asserted, even though they are combinational.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (lock_act) begin
        m0_gnt = !own_is_m1;
        m1_gnt = own_is_m1;
      end else if (m0_req && m1_req) begin
        m0_gnt = last_gnt_q;
        m1_gnt = !last_gnt_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end

    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 3'b000;
    if (m0_gnt) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_we    = m0_we;
    end else if (m1_gnt) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_we    = m1_we;
    end
  end

  always_comb begin
    state_d    = IDLE;
    lock_d     = 1'b0;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = 4'd0;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;

    if (m0_gnt) begin
      state_d    = OWN0;
      lock_d     = m0_lock;
      last_gnt_d = 1'b0;
      rd_pend_d  = (m0_we == 3'b000);
      rd_owner_d = 1'b0;
    end else if (m1_gnt) begin
      state_d    = OWN1;
      lock_d     = m1_lock;
      last_gnt_d = 1'b1;
      rd_pend_d  = (m1_we == 3'b000);
      rd_owner_d = 1'b1;
    end

    // lock_act already guarantees lock_cnt_q < MAX_CNT, so the increment saturates at MAX_CNT.
    if ((m0_gnt || m1_gnt) && lock_act && other_req) begin
      lock_cnt_d = lock_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_pend_q && !rd_owner_q;
  assign m1_rvalid = rd_pend_q && rd_owner_q;
  assign m0_rdata  = bus_rdata;
  assign m1_rdata  = bus_rdata;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Self-checking bench for localbus_arbiter: directed scenarios plus a
// randomized run compared against a behavioural arbitration model.
module tb_localbus_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_LOCK = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req [2];
  logic            lock [2];
  logic [XLEN-1:0] addr [2];
  logic [XLEN-1:0] wdata [2];
  logic [2:0]      we [2];
  logic [XLEN-1:0] bus_rdata;

  logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [XLEN-1:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [2:0]      bus_we;

  int checks = 0;
  int errors = 0;

  // model: who owned the bus last cycle (-1 none), whether it asked to lock,
  // the number of lock-forced grants so far, who won last, and pending read owner
  int m_owner, m_lock, m_cnt, m_last, m_rd;

  localbus_arbiter #(.XLEN(XLEN), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_lock(lock[0]), .m1_lock(lock[1]),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
    .m0_we(we[0]), .m1_we(we[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1; m_lock = 0; m_cnt = 0; m_last = 1; m_rd = -1;
  endfunction

  function automatic bit model_locked();
    return (m_owner >= 0) && (m_lock != 0) && req[m_owner] && (m_cnt < MAX_LOCK);
  endfunction

  function automatic int model_gnt();
    if (!rst_n) return -1;
    if (model_locked()) return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic void model_commit(int g);
    bit locked;
    locked = model_locked();
    if (g < 0) begin
      m_owner = -1; m_lock = 0; m_cnt = 0; m_rd = -1;
    end else begin
      if (locked && req[1-g]) m_cnt = (m_cnt + 1 > MAX_LOCK) ? MAX_LOCK : m_cnt + 1;
      else m_cnt = 0;
      m_owner = g;
      m_lock  = lock[g] ? 1 : 0;
      m_last  = g;
      m_rd    = (we[g] == 3'b000) ? g : -1;
    end
  endfunction

  task automatic set_m(int m, bit r, bit l, logic [XLEN-1:0] a, logic [XLEN-1:0] d, logic [2:0] w);
    req[m] = r; lock[m] = l; addr[m] = a; wdata[m] = d; we[m] = w;
  endtask

  task automatic tick();
    int g;
    g = model_gnt();
    @(posedge clk);
    model_commit(g);
    #1;
    bus_rdata = $urandom;
  endtask

  task automatic test_reset();
    set_m(0, 1, 0, 32'h10, 32'h0, 3'b000);
    set_m(1, 1, 0, 32'h20, 32'h0, 3'b000);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    checks++;
    if (bus_addr !== '0 || bus_we !== 3'b000) begin
      errors++; $display("FAIL reset_bus: addr %h we %b want 0", bus_addr, bus_we);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_read_alternate();
    logic [XLEN-1:0] rd0;
    set_m(0, 1, 0, 32'hA000, 32'h0, 3'b000);
    set_m(1, 1, 0, 32'hB000, 32'h0, 3'b000);
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || bus_addr !== 32'hA000) begin
      errors++; $display("FAIL rr_first: gnt %b addr %h want 10 a000", {m0_gnt, m1_gnt}, bus_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || bus_addr !== 32'hB000) begin
      errors++; $display("FAIL rr_second: gnt %b addr %h want 01 b000", {m0_gnt, m1_gnt}, bus_addr);
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== bus_rdata) begin
      errors++; $display("FAIL rd_m0: rvalid %b rdata %h want 10 %h", {m0_rvalid, m1_rvalid}, m0_rdata, bus_rdata);
    end
    tick();
    set_m(0, 0, 0, 32'h0, 32'h0, 3'b000);
    set_m(1, 0, 0, 32'h0, 32'h0, 3'b000);
    rd0 = bus_rdata;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== rd0 || {m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL rd_m1: rvalid %b rdata %h gnt %b want 01 %h 00", {m0_rvalid, m1_rvalid}, m1_rdata, {m0_gnt, m1_gnt}, rd0);
    end
    tick();
  endtask

  task automatic test_lock();
    set_m(0, 1, 1, 32'h100, 32'h1, 3'b001);
    set_m(1, 1, 0, 32'h200, 32'h2, 3'b001);
    for (int i = 0; i < MAX_LOCK + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== ((i <= MAX_LOCK) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL lock_seq[%0d]: gnt %b want %b", i, {m0_gnt, m1_gnt}, (i <= MAX_LOCK) ? 2'b10 : 2'b01);
      end
      tick();
    end
    set_m(1, 0, 0, 32'h200, 32'h2, 3'b001);
    tick();
    tick();
    set_m(0, 0, 1, 32'h100, 32'h1, 3'b001);
    set_m(1, 1, 0, 32'h200, 32'h2, 3'b001);
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL lock_release: gnt %b want 01", {m0_gnt, m1_gnt});
    end
    tick();
  endtask

  task automatic test_write();
    set_m(0, 0, 0, 32'h0, 32'h0, 3'b000);
    set_m(1, 1, 0, 32'h1000, 32'hDEADBEEF, 3'b011);
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || bus_addr !== 32'h1000 || bus_wdata !== 32'hDEADBEEF || bus_we !== 3'b011) begin
      errors++; $display("FAIL write_bus: gnt %b addr %h wdata %h we %b", m1_gnt, bus_addr, bus_wdata, bus_we);
    end
    tick();
    set_m(1, 0, 0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL write_rvalid: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    tick();
  endtask

  task automatic test_idle();
    set_m(0, 0, 1, 32'hFFFF, 32'h1234, 3'b111);
    set_m(1, 0, 1, 32'hEEEE, 32'h5678, 3'b111);
    @(negedge clk);
    checks++;
    if (bus_addr !== '0 || bus_wdata !== '0 || bus_we !== 3'b000 || {m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL idle_bus: addr %h wdata %h we %b gnt %b want all 0", bus_addr, bus_wdata, bus_we, {m0_gnt, m1_gnt});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_m(0, 1, 0, 32'h40, 32'h0, 3'b000);
    set_m(1, 0, 0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got %b want 1", m0_gnt);
    end
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 4'b0000) begin
      errors++; $display("FAIL mid_drop: rvalid %b gnt %b want 00 00", {m0_rvalid, m1_rvalid}, {m0_gnt, m1_gnt});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    set_m(1, 1, 0, 32'h80, 32'h0, 3'b000);
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || {m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL post_reset: rvalid %b gnt %b want 00 10", {m0_rvalid, m1_rvalid}, {m0_gnt, m1_gnt});
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    logic [1:0]      eg;
    logic [XLEN-1:0] ea, ed;
    logic [2:0]      ew;
    logic [1:0]      ev;
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        set_m(m, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom, $urandom,
              ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(1, 7)));
      end
      @(negedge clk);
      g  = model_gnt();
      eg = (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
      ea = (g >= 0) ? addr[g] : '0;
      ed = (g >= 0) ? wdata[g] : '0;
      ew = (g >= 0) ? we[g] : 3'b000;
      ev = (m_rd == 0) ? 2'b10 : (m_rd == 1) ? 2'b01 : 2'b00;
      checks++;
      if ({m0_gnt, m1_gnt} !== eg) begin
        errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", n, {m0_gnt, m1_gnt}, eg);
      end
      checks++;
      if (bus_addr !== ea || bus_wdata !== ed || bus_we !== ew) begin
        errors++; $display("FAIL rand_bus[%0d]: got %h %h %b want %h %h %b", n, bus_addr, bus_wdata, bus_we, ea, ed, ew);
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== ev || m0_rdata !== bus_rdata || m1_rdata !== bus_rdata) begin
        errors++; $display("FAIL rand_rd[%0d]: rvalid %b want %b", n, {m0_rvalid, m1_rvalid}, ev);
      end
      tick();
    end
  endtask

  initial begin
    bus_rdata = 32'h0BADF00D;
    model_reset();
    test_reset();
    test_read_alternate();
    test_lock();
    test_write();
    test_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/localbus_arbiter.md
LOCALBUS_ARBITER -- requirements
Module: localbus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter MAX_LOCK, default 4, maximum consecutive grants to one locked master while the other waits (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  master n requests a bus cycle.
REQ-006 SHALL have ports m0_lock / m1_lock  input  1  master n asks to keep the bus next cycle.
REQ-007 SHALL have ports m0_addr / m1_addr  input  XLEN  transaction address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  XLEN  write data.
REQ-009 SHALL have ports m0_we / m1_we  input  3  write-enable code, 3'b000 = read, same encoding as the core data port.
REQ-010 SHALL have ports m0_gnt / m1_gnt  output  1  combinational grant; the transaction is issued this cycle.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid for master n.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  XLEN  read data, equal to bus_rdata.
REQ-013 SHALL have ports bus_addr, bus_wdata  output  XLEN  and bus_we  output  3  localbus request side.
REQ-014 SHALL have port bus_rdata  input  XLEN  localbus read data, valid one cycle after the read is issued.

Function
REQ-015 SHALL grant at most one master per cycle; the granted master's addr/wdata/we SHALL drive bus_* combinationally in the same cycle.
REQ-016 With no grant, bus_addr, bus_wdata and bus_we SHALL be 0.
REQ-017 With only one master requesting, that master SHALL be granted.
REQ-018 With both requesting and no active lock, the master not granted most recently SHALL win (round-robin on register last_gnt).
REQ-019 FSM states IDLE, OWN0, OWN1 SHALL record the owner of the previous cycle: grant to m0 -> OWN0, to m1 -> OWN1, none -> IDLE.
REQ-020 Lock is active when the state is OWNn, mn_lock was high in that granted cycle (registered), mn_req is high now, and lock_cnt < MAX_LOCK.
REQ-021 An active lock SHALL grant the owner regardless of round-robin order.
REQ-022 lock_cnt SHALL increment on each lock-driven grant made while the other master requests, reset to 0 on any other grant or on an idle cycle, and saturate at MAX_LOCK.
REQ-023 At lock_cnt == MAX_LOCK with the other master requesting, the arbiter SHALL grant the other master (no starvation).
REQ-024 A lock SHALL be released the first cycle the owner drops req, even if lock remains high.
REQ-025 For a granted read (we == 0), the arbiter SHALL register rd_pend=1 and rd_owner; next cycle it SHALL assert mn_rvalid for rd_owner only, for exactly one cycle.
REQ-026 Granted writes SHALL NOT produce rvalid.
REQ-027 A new grant SHALL be allowed in the same cycle as the rvalid of a prior read; back-to-back reads from alternating masters SHALL each return data to the correct master.
REQ-028 m0_rdata and m1_rdata SHALL both equal bus_rdata; masters SHALL qualify the data with rvalid.

Reset
REQ-029 While rst_n is low: state=IDLE, last_gnt=1 (so m0 wins the first contention), lock_cnt=0, the registered lock=0, rd_pend=0, and both rvalid outputs=0.
REQ-030 Reset asserted mid-transaction SHALL drop any pending rvalid immediately; no rvalid SHALL follow the release of reset.
REQ-031 Grant outputs SHALL be 0 during reset regardless of req.

Verification
REQ-032 Both req=1, we=0, from reset -> m0_gnt cycle 1, m1_gnt cycle 2; rvalid on m0 cycle 2 and m1 cycle 3 with the matching bus_rdata.
REQ-033 m0 req+lock held, m1 req held, MAX_LOCK=4 -> m0 is granted 5 consecutive cycles (1 round-robin + 4 locked), then m1 is granted.
REQ-034 Single m1 write addr=0x1000, wdata=0xDEADBEEF, we=3'b011 -> bus_* carries those values the same cycle; no rvalid.
REQ-035 No requests -> bus_addr=0, bus_wdata=0, bus_we=0, no gnt, state IDLE.
REQ-036 m0 read granted, rst_n pulsed low before the next edge -> m0_rvalid stays 0; first grant after reset goes to m0 under contention.
